// File: rtl/byte_word_packer_pkg.sv
// packer_pkg: shared types and constants for the byte-to-word packer.
//   pk_state_t   : packer state (EMPTY = no byte held, HALF = high byte held)
//   out_word_t   : contents of the single output holding register
//   PAD_BYTE_DEF : default fill byte for odd-length frames
//   make_word    : builds an out_word_t from its two bytes and flags
package packer_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pk_state_t;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        padded;
  } out_word_t;

  localparam logic [7:0] PAD_BYTE_DEF = 8'h00;

  // The first byte of a pair is the high byte (MSB-first).
  function automatic out_word_t make_word(input logic [7:0] hi_byte,
                                          input logic [7:0] lo_byte,
                                          input logic       last,
                                          input logic       padded);
    out_word_t w;
    w.data   = {hi_byte, lo_byte};
    w.last   = last;
    w.padded = padded;
    return w;
  endfunction

endpackage

// File: rtl/byte_word_packer_if.sv
// byte_word_packer_if: byte input stream and word output stream of the packer.
//   in_data/in_valid/in_last/in_ready         : 8-bit stream into the packer
//   out_data/out_valid/out_last/out_padded/out_ready : 16-bit stream out
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. A source holding valid=1 keeps its payload until the transfer;
// ready never depends on valid on the same side.
//
// Modports:
//   slave  : the packer itself
//   master : the environment (byte producer and word consumer)
interface byte_word_packer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_padded;
  logic        out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_padded
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_padded
  );
endinterface

// File: rtl/byte_word_packer_event_counter.sv
// event_counter: free-running event counter that wraps modulo 2^W.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears count
//   inc   : count one event this cycle
//   count : number of events since reset (mod 2^W)
module event_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs a byte stream into 16-bit words, MSB-first.
// A frame ending on an odd byte is completed with PAD_BYTE in the low half.
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-high reset
//   bus        : byte input / word output streams (slave side)
//   word_count : words handed off on the output
//   pad_count  : padded words handed off on the output
//   dbg_state  : current packer state
module byte_word_packer
  import packer_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEF,
  parameter int         CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  byte_word_packer_if.slave    bus,
  output logic [CNT_W-1:0]     word_count,
  output logic [CNT_W-1:0]     pad_count,
  output pk_state_t            dbg_state
);

  pk_state_t  state_q, state_d;
  logic [7:0] hold_q, hold_d;
  out_word_t  out_q, emit_word;
  logic       out_valid_q;
  logic       emit;
  logic       in_fire;
  logic       out_fire;

  // The slot can take a new word when it is empty or drains this cycle.
  // Every accepted byte may produce a word, so this gates input directly.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = out_valid_q && bus.out_ready;

  assign bus.out_data   = out_q.data;
  assign bus.out_last   = out_q.last;
  assign bus.out_padded = out_q.padded;
  assign bus.out_valid  = out_valid_q;
  assign dbg_state      = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      hold_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    emit      = 1'b0;
    emit_word = '0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          if (bus.in_last) begin
            // Lone final byte: pad it out to a full word immediately.
            emit      = 1'b1;
            emit_word = make_word(bus.in_data, PAD_BYTE, 1'b1, 1'b1);
          end else begin
            hold_d  = bus.in_data;
            state_d = HALF;
          end
        end
      end
      HALF: begin
        if (in_fire) begin
          emit      = 1'b1;
          emit_word = make_word(hold_q, bus.in_data, bus.in_last, 1'b0);
          state_d   = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Output holding register. A new word may land in the same cycle the old
  // one drains, in which case valid simply stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (emit) begin
      out_q       <= emit_word;
      out_valid_q <= 1'b1;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end

  event_counter #(.W(CNT_W)) u_word_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_fire),
    .count (word_count)
  );

  event_counter #(.W(CNT_W)) u_pad_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_fire && out_q.padded),
    .count (pad_count)
  );

endmodule

// File: tb/tb_byte_word_packer.sv
module tb_byte_word_packer;
  import packer_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  byte_word_packer_if bus ();
  byte_word_packer_if bus_ee ();

  logic [31:0] word_count, pad_count;
  logic [31:0] word_count_ee, pad_count_ee;
  pk_state_t   dbg_state, dbg_state_ee;

  byte_word_packer #(.PAD_BYTE(8'h00), .CNT_W(32)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .word_count (word_count),
    .pad_count  (pad_count),
    .dbg_state  (dbg_state)
  );

  byte_word_packer #(.PAD_BYTE(8'hEE), .CNT_W(32)) u_dut_ee (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_ee),
    .word_count (word_count_ee),
    .pad_count  (pad_count_ee),
    .dbg_state  (dbg_state_ee)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid     = 1'b0;
    bus.in_data      = 8'h00;
    bus.in_last      = 1'b0;
    bus.out_ready    = 1'b0;
    bus_ee.in_valid  = 1'b0;
    bus_ee.in_data   = 8'h00;
    bus_ee.in_last   = 1'b0;
    bus_ee.out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = r;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.out_last !== 1'b0 ||
        bus.out_padded !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got v=%b d=%h l=%b p=%b expected 0", bus.out_valid,
                         bus.out_data, bus.out_last, bus.out_padded);
    end
    checks++;
    if (word_count !== 32'd0 || pad_count !== 32'd0 || dbg_state !== EMPTY) begin
      errors++; $display("FAIL reset_counters: got wc=%0d pc=%0d st=%0d expected 0", word_count,
                         pad_count, dbg_state);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_even_frame();
    apply_reset();
    drive(1'b1, 8'hA1, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 8'hB2, 1'b0, 1'b1);
    cyc();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hA1B2 || bus.out_last !== 1'b0 ||
        bus.out_padded !== 1'b0) begin
      errors++; $display("FAIL even_word0: got v=%b d=%h l=%b p=%b expected 1 a1b2 0 0",
                         bus.out_valid, bus.out_data, bus.out_last, bus.out_padded);
    end
    drive(1'b1, 8'hC3, 1'b0, 1'b1);
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0 || dbg_state !== HALF) begin
      errors++; $display("FAIL even_gap: got v=%b st=%0d expected v=0 st=HALF", bus.out_valid,
                         dbg_state);
    end
    drive(1'b1, 8'hD4, 1'b1, 1'b1);
    cyc();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'hC3D4 || bus.out_last !== 1'b1 ||
        bus.out_padded !== 1'b0) begin
      errors++; $display("FAIL even_word1: got v=%b d=%h l=%b p=%b expected 1 c3d4 1 0",
                         bus.out_valid, bus.out_data, bus.out_last, bus.out_padded);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    cyc();
    checks++;
    if (word_count !== 32'd2 || pad_count !== 32'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL even_counts: got wc=%0d pc=%0d v=%b expected 2 0 0", word_count,
                         pad_count, bus.out_valid);
    end
  endtask

  task automatic test_odd_frame();
    apply_reset();
    bus_ee.out_ready = 1'b1;
    bus_ee.in_valid  = 1'b1;
    bus_ee.in_data   = 8'h11;
    cyc();
    bus_ee.in_data = 8'h22;
    cyc();
    checks++;
    if (bus_ee.out_valid !== 1'b1 || bus_ee.out_data !== 16'h1122 || bus_ee.out_padded !== 1'b0) begin
      errors++; $display("FAIL odd_word0: got v=%b d=%h p=%b expected 1 1122 0", bus_ee.out_valid,
                         bus_ee.out_data, bus_ee.out_padded);
    end
    bus_ee.in_data = 8'h33;
    bus_ee.in_last = 1'b1;
    cyc();
    checks++;
    if (bus_ee.out_valid !== 1'b1 || bus_ee.out_data !== 16'h33EE || bus_ee.out_last !== 1'b1 ||
        bus_ee.out_padded !== 1'b1) begin
      errors++; $display("FAIL odd_word1: got v=%b d=%h l=%b p=%b expected 1 33ee 1 1",
                         bus_ee.out_valid, bus_ee.out_data, bus_ee.out_last, bus_ee.out_padded);
    end
    bus_ee.in_valid = 1'b0;
    bus_ee.in_last  = 1'b0;
    cyc();
    checks++;
    if (word_count_ee !== 32'd2 || pad_count_ee !== 32'd1) begin
      errors++; $display("FAIL odd_counts: got wc=%0d pc=%0d expected 2 1", word_count_ee,
                         pad_count_ee);
    end
    bus_ee.out_ready = 1'b0;
  endtask

  task automatic test_single_byte();
    apply_reset();
    drive(1'b1, 8'h5A, 1'b1, 1'b1);
    cyc();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h5A00 || bus.out_last !== 1'b1 ||
        bus.out_padded !== 1'b1 || dbg_state !== EMPTY) begin
      errors++; $display("FAIL single_word: got v=%b d=%h l=%b p=%b st=%0d expected 1 5a00 1 1 EMPTY",
                         bus.out_valid, bus.out_data, bus.out_last, bus.out_padded, dbg_state);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    cyc();
    checks++;
    if (word_count !== 32'd1 || pad_count !== 32'd1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_counts: got wc=%0d pc=%0d v=%b expected 1 1 0", word_count,
                         pad_count, bus.out_valid);
    end
  endtask

  task automatic test_back_pressure();
    apply_reset();
    drive(1'b1, 8'h10, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 8'h20, 1'b0, 1'b0);
    cyc();
    drive(1'b1, 8'h30, 1'b1, 1'b0);
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== 16'h1020) begin
        errors++; $display("FAIL stall_%0d: got rdy=%b v=%b d=%h expected 0 1 1020", i,
                           bus.in_ready, bus.out_valid, bus.out_data);
      end
      cyc();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL release_ready: got %b expected 1", bus.in_ready);
    end
    cyc();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h3000 || bus.out_padded !== 1'b1 ||
        word_count !== 32'd1) begin
      errors++; $display("FAIL same_cycle_emit: got v=%b d=%h p=%b wc=%0d expected 1 3000 1 1",
                         bus.out_valid, bus.out_data, bus.out_padded, word_count);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    cyc();
    checks++;
    if (word_count !== 32'd2 || pad_count !== 32'd1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_counts: got wc=%0d pc=%0d v=%b expected 2 1 0", word_count,
                         pad_count, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    drive(1'b1, 8'h5A, 1'b1, 1'b1);
    cyc();
    drive(1'b1, 8'h77, 1'b0, 1'b1);
    cyc();
    checks++;
    if (word_count !== 32'd1 || dbg_state !== HALF) begin
      errors++; $display("FAIL mid_pre_half: got wc=%0d st=%0d expected 1 HALF", word_count, dbg_state);
    end
    drive(1'b1, 8'h88, 1'b0, 1'b0);
    cyc();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h7788) begin
      errors++; $display("FAIL mid_pending: got v=%b d=%h expected 1 7788", bus.out_valid, bus.out_data);
    end
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    cyc();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.out_last !== 1'b0 ||
        bus.out_padded !== 1'b0 || word_count !== 32'd0 || pad_count !== 32'd0 ||
        dbg_state !== EMPTY || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got v=%b d=%h l=%b p=%b wc=%0d pc=%0d st=%0d rdy=%b expected all 0, rdy 1",
                         bus.out_valid, bus.out_data, bus.out_last, bus.out_padded, word_count,
                         pad_count, dbg_state, bus.in_ready);
    end
    cyc();
    rst = 1'b0;
    cyc();
    drive(1'b1, 8'h01, 1'b0, 1'b1);
    cyc();
    drive(1'b1, 8'h02, 1'b1, 1'b1);
    cyc();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0102 || bus.out_last !== 1'b1 ||
        bus.out_padded !== 1'b0) begin
      errors++; $display("FAIL post_reset_word: got v=%b d=%h l=%b p=%b expected 1 0102 1 0",
                         bus.out_valid, bus.out_data, bus.out_last, bus.out_padded);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    cyc();
    cyc();
    checks++;
    if (word_count !== 32'd1 || pad_count !== 32'd0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_only: got wc=%0d pc=%0d v=%b expected 1 0 0", word_count,
                         pad_count, bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic [17:0] exp_q[$];
    logic [17:0] exp_w;
    logic [7:0]  half_b;
    logic        have_half;
    int          sent;
    int          cycles;
    int          got;
    int          got_pad;
    int          bad_ready;
    apply_reset();
    have_half = 1'b0;
    half_b    = 8'h00;
    sent      = 0;
    cycles    = 0;
    got       = 0;
    got_pad   = 0;
    bad_ready = 0;
    while (sent < 1000 && cycles < 20000) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'($urandom_range(0, 255));
      bus.in_last   = (sent == 999) ? 1'b1 : ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) bad_ready++;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra_word: got %h expected none", bus.out_data);
        end else begin
          exp_w = exp_q.pop_front();
          if ({bus.out_data, bus.out_last, bus.out_padded} !== exp_w) begin
            errors++; $display("FAIL rand_word_%0d: got d=%h l=%b p=%b expected d=%h l=%b p=%b", got,
                               bus.out_data, bus.out_last, bus.out_padded, exp_w[17:2], exp_w[1],
                               exp_w[0]);
          end
        end
        got++;
        if (bus.out_padded) got_pad++;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (have_half) begin
          exp_q.push_back({half_b, bus.in_data, bus.in_last, 1'b0});
          have_half = 1'b0;
        end else if (bus.in_last) begin
          exp_q.push_back({bus.in_data, 8'h00, 1'b1, 1'b1});
        end else begin
          half_b    = bus.in_data;
          have_half = 1'b1;
        end
        sent++;
      end
      cyc();
      cycles++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
      #1;
      if (bus.out_valid) begin
        checks++;
        exp_w = exp_q.pop_front();
        if ({bus.out_data, bus.out_last, bus.out_padded} !== exp_w) begin
          errors++; $display("FAIL rand_drain_word: got d=%h l=%b p=%b expected d=%h l=%b p=%b",
                             bus.out_data, bus.out_last, bus.out_padded, exp_w[17:2], exp_w[1], exp_w[0]);
        end
        got++;
        if (bus.out_padded) got_pad++;
      end
      cyc();
    end
    checks++;
    if (sent != 1000 || exp_q.size() != 0 || have_half) begin
      errors++; $display("FAIL rand_complete: got sent=%0d left=%0d half=%b expected 1000 0 0", sent,
                         exp_q.size(), have_half);
    end
    checks++;
    if (bad_ready != 0) begin
      errors++; $display("FAIL rand_in_ready: got %0d bad cycles expected 0", bad_ready);
    end
    checks++;
    if (word_count !== 32'(got) || pad_count !== 32'(got_pad) || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rand_counts: got wc=%0d pc=%0d v=%b expected %0d %0d 0", word_count,
                         pad_count, bus.out_valid, got, got_pad);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    idle_inputs();
    test_reset();
    test_even_frame();
    test_odd_frame();
    test_single_byte();
    test_back_pressure();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
